// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: FSM states, fetch-entry layout
// and the default reset PC.
package if_fetch_unit_pkg;

  localparam logic [31:0] ResetPcDefault = 32'hBFC0_0000;
  localparam int unsigned PcW            = 32;
  localparam int unsigned InstrW         = 32;

  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PcW-1:0]    pc;
    logic [InstrW-1:0] instr;
    logic              adel;
  } fetch_entry_t;

  function automatic logic pc_misaligned(input logic [PcW-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit_skid_buf.sv
// Output register plus one skid entry between the fetch FSM and the F/D register.
// Caller guarantees load_i is only raised while the skid slot is empty.
module if_fetch_unit_skid_buf
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PcW-1:0] ResetPc = ResetPcDefault
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         load_i,
  input  fetch_entry_t load_entry_i,
  input  logic         consume_i,
  output fetch_entry_t out_entry_o,
  output logic         out_valid_o,
  output logic         skid_valid_o
);

  fetch_entry_t out_q, out_d;
  fetch_entry_t skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         out_free;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    out_free     = !out_valid_q || consume_i;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      out_d.adel   = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_d       = load_entry_i;
        skid_valid_d = load_i;
      end else if (load_i) begin
        // Bypass straight into the output so a same-cycle consume leaves no bubble.
        out_d       = load_entry_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
        out_d.adel  = 1'b0;
      end
    end else if (load_i) begin
      skid_d       = load_entry_i;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q        <= '{pc: ResetPc, instr: '0, adel: 1'b0};
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_entry_o  = out_q;
  assign out_valid_o  = out_valid_q;
  assign skid_valid_o = skid_valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives the req/addr_ok/data_ok
// instruction bus with one outstanding transaction, and handles stalls/redirects.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic [31:0] pcF,
  output logic [31:0] instrF,
  output logic        instr_validF,
  output logic        adelF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic         cancel_q, cancel_d;
  logic         req_pend_q, req_pend_d;

  logic         skid_valid;
  logic         issue_new;
  logic         accepted;
  logic         load;
  fetch_entry_t load_entry;
  fetch_entry_t out_entry;

  // A pending request keeps its latched address even if a redirect moves fetch_pc.
  always_comb begin
    issue_new = (state_q == StReq) && !req_pend_q && !skid_valid &&
                !pc_misaligned(fetch_pc_q);
    inst_req  = rst && (req_pend_q || issue_new);
    inst_addr = req_pend_q ? req_addr_q : fetch_pc_q;
    accepted  = inst_req && inst_addr_ok;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    req_addr_d = req_addr_q;
    cancel_d   = cancel_q;
    req_pend_d = req_pend_q;
    load       = 1'b0;
    load_entry = '{pc: req_pc_q, instr: inst_rdata, adel: 1'b0};

    unique case (state_q)
      StReq: begin
        if (accepted) begin
          req_pc_d   = inst_addr;
          req_pend_d = 1'b0;
          state_d    = StWait;
          // A stale request was redirected away; fetch_pc already holds the target.
          if (!cancel_q) fetch_pc_d = fetch_pc_q + 32'd4;
        end else if (inst_req) begin
          req_pend_d = 1'b1;
          req_addr_d = inst_addr;
        end else if (!req_pend_q && !skid_valid && pc_misaligned(fetch_pc_q)) begin
          load       = 1'b1;
          load_entry = '{pc: fetch_pc_q, instr: '0, adel: 1'b1};
          state_d    = StHalt;
        end
      end
      StWait: begin
        if (inst_data_ok) begin
          state_d  = StReq;
          cancel_d = 1'b0;
          load     = !cancel_q;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StReq;
    endcase

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      load       = 1'b0;
      if (inst_req || (state_q == StWait && !inst_data_ok)) cancel_d = 1'b1;
      if (state_d == StHalt) state_d = StReq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      req_addr_q <= RESET_PC;
      cancel_q   <= 1'b0;
      req_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      req_addr_q <= req_addr_d;
      cancel_q   <= cancel_d;
      req_pend_q <= req_pend_d;
    end
  end

  if_fetch_unit_skid_buf #(
    .ResetPc(RESET_PC)
  ) u_skid_buf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .flush_i     (redirect),
    .load_i      (load),
    .load_entry_i(load_entry),
    .consume_i   (!stallF),
    .out_entry_o (out_entry),
    .out_valid_o (instr_validF),
    .skid_valid_o(skid_valid)
  );

  assign pcF    = out_entry.pc;
  assign instrF = out_entry.instr;
  assign adelF  = out_entry.adel;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench: the expected instruction stream is program order from the
// last redirect/reset target; a monitor pops it on every consumption.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic [31:0] inst_rdata = 32'h0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] pcF, instrF;
  logic        instr_validF, adelF;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallF      (stallF),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_rdata  (inst_rdata),
    .inst_data_ok(inst_data_ok),
    .pcF         (pcF),
    .instrF      (instrF),
    .instr_validF(instr_validF),
    .adelF       (adelF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_cons = 0;
  exp_t        exp_q[$];
  logic [31:0] acc_log[$];

  // Memory model controls/state.
  int          mem_mode = 1;  // 1: zero-wait, 0: random handshake/latency
  int          mem_hold = 0;
  bit          mem_out = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  bit          prev_pend = 0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Program-order stream from a fetch target; a misaligned target yields one fault entry.
  task automatic expect_stream(input logic [31:0] start);
    exp_q.delete();
    if (start[1:0] != 2'b00) begin
      exp_q.push_back('{start, 32'h0, 1'b1});
    end else begin
      for (int k = 0; k < 1024; k++) begin
        logic [31:0] a;
        a = start + 32'(4 * k);
        exp_q.push_back('{a, memf(a), 1'b0});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    expect_stream(t);
    tick();
    redirect    = 1'b0;
    redirect_pc = $urandom;
  endtask

  function automatic logic [31:0] acc_at(input int i);
    if (i >= 0 && i < acc_log.size()) return acc_log[i];
    return 32'hDEAD_DEAD;
  endfunction

  // Monitor: a consumption happens at the coming edge when valid, not stalled, no redirect.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && !redirect && instr_validF && !stallF) begin
        n_cons++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_delivery: pcF %h while nothing expected", pcF);
        end else begin
          e = exp_q.pop_front();
          check("pcF", pcF, e.pc);
          check("instrF", instrF, e.instr);
          check("adelF", 32'(adelF), 32'(e.adel));
        end
      end
    end
  end

  // Instruction memory: one outstanding transaction, also checks bus protocol.
  initial begin : memory
    bit ok;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_out      = 0;
        prev_pend    = 0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
      end else if (mem_out) begin
        inst_addr_ok = 1'b0;
        prev_pend    = 0;
        check("no_req_while_outstanding", 32'(inst_req), 32'd0);
        if (mem_cnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = memf(mem_addr);
          mem_out      = 0;
        end else begin
          inst_data_ok = 1'b0;
          inst_rdata   = $urandom;
          mem_cnt--;
        end
      end else begin
        inst_data_ok = 1'b0;
        if (prev_pend) begin
          check("req_held", 32'(inst_req), 32'd1);
          check("addr_held", inst_addr, prev_addr);
        end
        ok = 0;
        if (inst_req) begin
          ok = (mem_mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
          if (mem_hold > 0) begin
            ok = 0;
            mem_hold--;
          end
          if (ok) begin
            acc_log.push_back(inst_addr);
            mem_out  = 1;
            mem_addr = inst_addr;
            mem_cnt  = (mem_mode == 1) ? 0 : $urandom_range(0, 3);
          end
          prev_pend = !ok;
          prev_addr = inst_addr;
        end else begin
          prev_pend = 0;
        end
        inst_addr_ok = ok;
      end
    end
  end

  initial begin : timeout
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    n_errors++;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin : stimulus
    int          base;
    int          c0;
    int          guard;
    bit          halted;
    logic [31:0] stale;
    logic [31:0] t;

    // Reset values
    #1 rst = 1'b0;
    #1;
    check("rst_pcF", pcF, RESET_PC);
    check("rst_instrF", instrF, 32'h0);
    check("rst_valid", 32'(instr_validF), 32'd0);
    check("rst_adel", 32'(adelF), 32'd0);
    check("rst_req", 32'(inst_req), 32'd0);
    tick();
    tick();
    expect_stream(RESET_PC);
    rst = 1'b1;

    // 1: zero-wait sequential fetch
    repeat (8) tick();
    for (int i = 0; i < 3; i++) check($sformatf("t1_addr%0d", i), acc_at(i), RESET_PC + 32'(4 * i));

    // 2: stall holds output, skid fills, no new request, no bubble on release
    guard = 0;
    while (!instr_validF && guard < 20) begin
      tick();
      guard++;
    end
    check("t2_valid_seen", 32'(instr_validF), 32'd1);
    stallF = 1'b1;
    repeat (6) tick();
    check("t2_req_skid_full", 32'(inst_req), 32'd0);
    check("t2_hold_valid", 32'(instr_validF), 32'd1);
    check("t2_hold_pc", pcF, exp_q[0].pc);
    stallF = 1'b0;
    tick();
    check("t2_no_bubble", 32'(instr_validF), 32'd1);
    check("t2_next_pc", pcF, exp_q[0].pc);

    // 3: redirect while waiting for data
    guard = 0;
    while (!mem_out && guard < 20) begin
      tick();
      guard++;
    end
    check("t3_in_wait", 32'(mem_out), 32'd1);
    base = acc_log.size();
    do_redirect(32'h8000_0100);
    check("t3_flushed", 32'(instr_validF), 32'd0);
    repeat (6) tick();
    check("t3_target_addr", acc_at(base), 32'h8000_0100);

    // 4: redirect while a request waits for addr_ok
    guard = 0;
    while (!(inst_req && !mem_out) && guard < 20) begin
      tick();
      guard++;
    end
    base     = acc_log.size();
    stale    = acc_at(base - 1) + 32'd4;
    mem_hold = 3;
    do_redirect(32'h8000_0200);
    repeat (10) tick();
    check("t4_stale_addr", acc_at(base), stale);
    check("t4_target_addr", acc_at(base + 1), 32'h8000_0200);

    // 5: misaligned target halts with a fault entry, later redirect resumes
    do_redirect(32'h8000_0102);
    base = acc_log.size();
    c0   = n_cons;
    repeat (8) tick();
    check("t5_no_bus_req", 32'(acc_log.size()), 32'(base));
    check("t5_req_low", 32'(inst_req), 32'd0);
    check("t5_one_delivery", 32'(n_cons), 32'(c0 + 1));
    do_redirect(32'h8000_0300);
    repeat (6) tick();
    check("t5_resume_addr", acc_at(base), 32'h8000_0300);

    // 6: asynchronous reset mid-transaction
    guard = 0;
    while (!mem_out && guard < 20) begin
      tick();
      guard++;
    end
    #2 rst = 1'b0;
    #1;
    check("t6_pcF", pcF, RESET_PC);
    check("t6_instrF", instrF, 32'h0);
    check("t6_valid", 32'(instr_validF), 32'd0);
    check("t6_adel", 32'(adelF), 32'd0);
    check("t6_req", 32'(inst_req), 32'd0);
    exp_q.delete();
    tick();
    tick();
    base = acc_log.size();
    expect_stream(RESET_PC);
    rst = 1'b1;
    repeat (6) tick();
    check("t6_first_addr", acc_at(base), RESET_PC);

    // Random phase: random memory timing, stalls and redirects
    mem_mode = 0;
    halted   = 0;
    c0       = n_cons;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stallF = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0 || (halted && $urandom_range(0, 7) == 0)) begin
        t = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
        if ($urandom_range(0, 5) == 0) t[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
        halted = (t[1:0] != 2'b00);
        do_redirect(t);
      end else begin
        tick();
      end
    end
    stallF = 1'b0;
    repeat (20) tick();
    check("rand_progress", 32'(n_cons - c0 > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
